// File: rtl/fix_tx_scheduler.sv
// Round-robin arbiter for the single outbound FIX message-creation path.
// Latches the winner's type/host, pulses start, and holds until done or watchdog expiry.
module fix_tx_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int HOST_W  = 8,
    parameter int TYPE_W  = 4,
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 11
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ*TYPE_W-1:0]  req_type_i,
    input  logic [NUM_REQ*HOST_W-1:0]  req_host_i,
    input  logic                       done_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic                       start_o,
    output logic [TYPE_W-1:0]          message_type_o,
    output logic [HOST_W-1:0]          host_addr_o,
    output logic                       busy_o,
    output logic                       abort_o,
    output logic                       timeout_err_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    rr_ptr_q;
    logic [IDX_W-1:0]    win_q;
    logic [TO_W-1:0]     wd_q;
    logic [TYPE_W-1:0]   type_q;
    logic [HOST_W-1:0]   host_q;
    logic [NUM_REQ-1:0]  gnt_q;
    logic                start_q;
    logic                busy_q;
    logic                abort_q;
    logic                err_q;

    logic [TYPE_W-1:0]   type_a [NUM_REQ];
    logic [HOST_W-1:0]   host_a [NUM_REQ];
    logic [NUM_REQ-1:0]  elig;
    logic                pick_valid;
    logic [IDX_W-1:0]    pick_idx;
    logic [IDX_W-1:0]    rr_d;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            type_a[i] = req_type_i[i*TYPE_W +: TYPE_W];
            host_a[i] = req_host_i[i*HOST_W +: HOST_W];
            // Type 0 means "no message": such a requester is never eligible.
            elig[i]   = req_i[i] && (type_a[i] != '0);
        end
    end

    // Scan from the highest offset down so the nearest eligible index after rr_ptr wins.
    always_comb begin : pick_c
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        // NOTE: every combinational output gets a default first so no latch is inferred.
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (elig[cand_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    assign rr_d = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;

    // NOTE: state uses non-blocking assignments; reset is synchronous, sampled at the clock edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            win_q    <= '0;
            wd_q     <= '0;
            type_q   <= '0;
            host_q   <= '0;
            gnt_q    <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            abort_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            start_q <= 1'b0;
            gnt_q   <= '0;
            abort_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pick_valid) begin
                        state_q <= S_START;
                        win_q   <= pick_idx;
                        type_q  <= type_a[pick_idx];
                        host_q  <= host_a[pick_idx];
                        start_q <= 1'b1;
                        gnt_q   <= NUM_REQ'(1) << pick_idx;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    state_q <= S_WAIT;
                    wd_q    <= '0;
                end
                S_WAIT: begin
                    // Completion takes priority over a coincident watchdog expiry.
                    if (done_i) begin
                        state_q  <= S_GAP;
                        rr_ptr_q <= rr_d;
                        wd_q     <= '0;
                    end else if (wd_q == TO_W'(TIMEOUT - 1)) begin
                        state_q  <= S_GAP;
                        rr_ptr_q <= rr_d;
                        abort_q  <= 1'b1;
                        err_q    <= 1'b1;
                        wd_q     <= '0;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                S_GAP: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    type_q  <= '0;
                    host_q  <= '0;
                    wd_q    <= '0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt_o          = gnt_q;
    assign start_o        = start_q;
    assign message_type_o = type_q;
    assign host_addr_o    = host_q;
    assign busy_o         = busy_q;
    assign abort_o        = abort_q;
    assign timeout_err_o  = err_q;

endmodule

// File: tb/tb_fix_tx_scheduler.sv
// Directed and randomized checks of fix_tx_scheduler against a transaction-level
// round-robin model (scan from pointer modulo NUM_REQ, sticky error flag).
module tb_fix_tx_scheduler;

    localparam int NR  = 4;
    localparam int HW  = 8;
    localparam int TW  = 4;
    localparam int TO  = 16;
    localparam int TOW = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [NR-1:0]       req_i;
    logic [NR*TW-1:0]    req_type_i;
    logic [NR*HW-1:0]    req_host_i;
    logic                done_i;
    logic [NR-1:0]       gnt_o;
    logic                start_o;
    logic [TW-1:0]       message_type_o;
    logic [HW-1:0]       host_addr_o;
    logic                busy_o;
    logic                abort_o;
    logic                timeout_err_o;

    logic [TW-1:0]       typ [NR];
    logic [HW-1:0]       hst [NR];

    int                  n_tests = 0;
    int                  n_fail  = 0;
    int                  rr_m    = 0;
    logic                err_m   = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        req_type_i = '0;
        req_host_i = '0;
        for (int i = 0; i < NR; i++) begin
            req_type_i[i*TW +: TW] = typ[i];
            req_host_i[i*HW +: HW] = hst[i];
        end
    end

    fix_tx_scheduler #(
        .NUM_REQ(NR), .HOST_W(HW), .TYPE_W(TW), .TIMEOUT(TO), .TO_W(TOW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_i          (req_i),
        .req_type_i     (req_type_i),
        .req_host_i     (req_host_i),
        .done_i         (done_i),
        .gnt_o          (gnt_o),
        .start_o        (start_o),
        .message_type_o (message_type_o),
        .host_addr_o    (host_addr_o),
        .busy_o         (busy_o),
        .abort_o        (abort_o),
        .timeout_err_o  (timeout_err_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic s, input logic [NR-1:0] g,
                             input logic [TW-1:0] t, input logic [HW-1:0] h,
                             input logic b, input logic ab);
        check({tag, ".start"}, 32'(start_o), 32'(s));
        check({tag, ".gnt"},   32'(gnt_o), 32'(g));
        check({tag, ".type"},  32'(message_type_o), 32'(t));
        check({tag, ".host"},  32'(host_addr_o), 32'(h));
        check({tag, ".busy"},  32'(busy_o), 32'(b));
        check({tag, ".abort"}, 32'(abort_o), 32'(ab));
        check({tag, ".err"},   32'(timeout_err_o), 32'(err_m));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Model: first requester with req set and nonzero type, scanning rr_m, rr_m+1, ... mod NR.
    function automatic int pick(input logic [NR-1:0] r);
        for (int k = 0; k < NR; k++) begin
            int idx;
            idx = (rr_m + k) % NR;
            if (r[idx] && typ[idx] != '0) return idx;
        end
        return -1;
    endfunction

    task automatic do_reset(input string tag);
        rst    = 1'b0;
        req_i  = '0;
        done_i = 1'b0;
        cyc();
        err_m = 1'b0;
        rr_m  = 0;
        check_out(tag, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        rst = 1'b1;
    endtask

    // Called at an IDLE cycle with inputs already set. d = cycle after start when done_i
    // is high (1..TO); d = 0 means done never arrives and the watchdog fires.
    task automatic run_msg(input string tag, input int d, input bit early_done);
        int            w;
        int            nwait;
        logic [TW-1:0] et;
        logic [HW-1:0] eh;
        w = pick(req_i);
        if (w < 0) begin
            cyc();
            check_out({tag, ".noelig"}, 1'b0, '0, '0, '0, 1'b0, 1'b0);
            return;
        end
        et = typ[w];
        eh = hst[w];
        cyc();
        check_out({tag, ".st"}, 1'b1, NR'(1) << w, et, eh, 1'b1, 1'b0);
        req_i[w] = 1'b0;
        done_i   = early_done;
        typ[w]   = TW'($urandom);
        hst[w]   = HW'($urandom);
        nwait    = (d == 0) ? TO : d;
        for (int k = 1; k <= nwait; k++) begin
            cyc();
            done_i = (d != 0) && (k == d);
            check_out({tag, ".wait"}, 1'b0, '0, et, eh, 1'b1, 1'b0);
        end
        cyc();
        done_i = 1'b0;
        if (d == 0) err_m = 1'b1;
        check_out({tag, ".gap"}, 1'b0, '0, et, eh, 1'b1, d == 0);
        rr_m = (w + 1) % NR;
        cyc();
        check_out({tag, ".idle"}, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            typ[i] = '0;
            hst[i] = '0;
        end
        rst    = 1'b0;
        req_i  = '0;
        done_i = 1'b0;
        cyc();
        do_reset("rst0");

        // Single requester, done 10 cycles after start.
        typ[0] = 4'h1;
        hst[0] = 8'h05;
        req_i  = 4'b0001;
        run_msg("t1", 10, 1'b0);

        // All four requesting from a fresh pointer: order 0,1,2,3, then wrap back to 0.
        do_reset("rst2");
        for (int i = 0; i < NR; i++) begin
            typ[i] = TW'($urandom_range(1, 15));
            hst[i] = HW'($urandom);
        end
        req_i = 4'b1111;
        for (int i = 0; i < NR; i++) run_msg("t2", 3, 1'b0);
        typ[0]   = 4'h7;
        req_i[0] = 1'b1;
        run_msg("t2wrap", 3, 1'b0);

        // Type-0 requester is never granted.
        typ[0] = 4'h3;
        typ[2] = 4'h0;
        hst[2] = 8'hAA;
        req_i  = 4'b0101;
        run_msg("t3", 3, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cyc();
            check_out("t3.type0", 1'b0, '0, '0, '0, 1'b0, 1'b0);
        end

        // Watchdog expiry, then the pending requester is served.
        typ[0] = 4'h9;
        typ[1] = 4'h2;
        req_i  = 4'b0011;
        run_msg("t4to", 0, 1'b0);
        run_msg("t4next", 4, 1'b0);

        // Reset in the middle of WAIT; a late done_i has no effect.
        typ[1] = 4'h4;
        hst[1] = 8'h31;
        req_i  = 4'b0010;
        cyc();
        check_out("t6.st", 1'b1, 4'b0010, 4'h4, 8'h31, 1'b1, 1'b0);
        req_i = '0;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        err_m = 1'b0;
        rr_m  = 0;
        check_out("t6.rst", 1'b0, '0, '0, '0, 1'b0, 1'b0);
        rst    = 1'b1;
        done_i = 1'b1;
        cyc();
        done_i = 1'b0;
        check_out("t6.late", 1'b0, '0, '0, '0, 1'b0, 1'b0);
        cyc();
        check_out("t6.late2", 1'b0, '0, '0, '0, 1'b0, 1'b0);

        // done_i coincides with expiry; then done_i during START is ignored.
        typ[3] = 4'hC;
        hst[3] = 8'h77;
        req_i  = 4'b1000;
        run_msg("t5edge", TO, 1'b0);
        req_i = 4'b1000;
        typ[3] = 4'h5;
        run_msg("t5early", 4, 1'b1);

        // Randomized traffic.
        for (int it = 0; it < 30; it++) begin
            int d;
            for (int i = 0; i < NR; i++) begin
                typ[i] = ($urandom_range(0, 3) == 0) ? '0 : TW'($urandom_range(1, 15));
                hst[i] = HW'($urandom);
            end
            req_i = NR'($urandom_range(0, 15));
            d = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, TO);
            run_msg("rnd", d, $urandom_range(0, 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fix_tx_scheduler.md
Name: fix_tx_scheduler

Overview:
- Schedules and arbitrates the single outbound message-creation path (message builder, serialising FSM, checksum) between NUM_REQ requesters, e.g. per-host session slots or the heartbeat timer.
- Grants one requester at a time using round-robin, then pulses start with the winner's message type and target host.
- Holds both values stable until the serialiser reports completion or a watchdog expires.
- Sits between the session layer and the message-creation datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
HOST_W, 8, host address width (matches HOST_ADDR_WIDTH)
TYPE_W, 4, message type code width
TIMEOUT, 1024, max cycles in WAIT before abort (>=2)
TO_W, 11, watchdog counter width (must hold TIMEOUT)

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous active-low reset (rst==0 at a clk edge resets)
req_i  in  NUM_REQ  level request per requester
req_type_i  in  NUM_REQ*TYPE_W  message type per requester, slice i = bits [i*TYPE_W +: TYPE_W]
req_host_i  in  NUM_REQ*HOST_W  target host per requester, same slicing
done_i  in  1  message fully serialised (end pulse from serialiser)
gnt_o  out  NUM_REQ  one-hot acceptance pulse to winner
start_o  out  1  one-cycle start pulse to message builder
message_type_o  out  TYPE_W  type for the current message
host_addr_o  out  HOST_W  host for the current message
busy_o  out  1  high from START through GAP
abort_o  out  1  one-cycle pulse on watchdog expiry
timeout_err_o  out  1  sticky watchdog error flag

Behaviour:
- Reset (rst==0): state=IDLE, rr_ptr=0, watchdog=0. All outputs are 0, including message_type_o, host_addr_o and timeout_err_o.
- A requester is eligible when req_i[i]==1 and its type slice !=0. Type 0 means "no message": it is never granted and never acknowledged.
- IDLE:
  - If any requester is eligible, pick the first eligible index scanning rr_ptr, rr_ptr+1, … (mod NUM_REQ).
  - Register its index, type and host, then go to START.
- START (1 cycle):
  - start_o=1 and gnt_o[win]=1 for exactly this cycle.
  - message_type_o/host_addr_o show the latched values; they stay stable through WAIT and GAP.
  - Next state is WAIT.
- WAIT:
  - The watchdog increments each cycle from 0.
  - done_i=1: go to GAP; rr_ptr = win+1 (wrap to 0 after NUM_REQ-1).
  - Else, if watchdog==TIMEOUT-1: abort_o=1 for 1 cycle, timeout_err_o<=1, rr_ptr=win+1, go to GAP.
  - If done_i and expiry fall in the same cycle, done wins: no abort.
- GAP (1 cycle):
  - Watchdog cleared.
  - message_type_o/host_addr_o are cleared to 0 on exit to IDLE.
  - Guarantees a 1-cycle bubble so the serialiser end and the next start never overlap.
- Latency: eligible request in IDLE at edge n → start_o/gnt_o at cycle n+1. Minimum spacing between start pulses is 4 cycles: START, WAIT with done, GAP, IDLE evaluation.
- busy_o=1 in START, WAIT and GAP.
- done_i outside WAIT, including the START cycle, is ignored.
- Requesters must drop req_i within 1 cycle after gnt_o. A request still high after GAP is treated as a new request. A request dropped before grant is simply not considered.
- Request/type/host inputs are sampled only in IDLE; changes during START/WAIT/GAP have no effect on the current message.
- timeout_err_o clears only on reset.
- Reset asserted mid-message: return to IDLE immediately at that edge with all outputs 0. No abort pulse is generated.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Reset, then req_i=4'b0001, type0=4'h1, host0=8'h05; done_i 10 cycles after start → start_o and gnt_o=0001 one cycle after the request; message_type_o=1 and host_addr_o=05 stable until GAP; busy_o drops 2 cycles after done_i.
2. req_i=4'b1111 held, each requester drops on its gnt, done_i 3 cycles after each start → grant order 0,1,2,3; rr_ptr wraps; next grant after a re-request of 0 goes to index 0.
3. req_i=4'b0101 with type2=0 → only index 0 is granted; index 2 never gets gnt_o.
4. No done_i after start, TIMEOUT=16 → abort_o pulses on the 16th WAIT cycle; timeout_err_o=1 and stays high; the next pending requester is granted afterwards.
5. done_i asserted in the same cycle the watchdog would expire → no abort_o; timeout_err_o stays 0.
6. rst driven low during WAIT → at the next edge state=IDLE and all outputs are 0; done_i arriving after reset produces no effect.
